instr_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of `cpu`. It owns the fetch program counter and issues word reads to a synchronous single-port instruction memory. Returned words are buffered, tagged with their PC, in a small prefetch FIFO and supplied to the core's `instruction` input through a valid/ready handshake. Core-side redirects (branch/jump/trap) flush all buffered and in-flight words and restart fetch at the new PC.

---
 rtl/instr_fetch_unit.sv | 96 +++++++++
 tb/tb_instr_fetch_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues reads to a synchronous
// instruction memory and buffers returned words with their PCs in a prefetch FIFO.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instruction,
  output logic [31:0]       instr_pc,
  output logic [31:0]       fetch_pc,
  output logic              misalign_err
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   word_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic [CW:0]   credit_used;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Credits count both buffered and in-flight words, so a returning read always has a slot.
  always_comb begin
    credit_used = {1'b0, count} + (CW + 1)'(inflight);
    imem_rd     = !rst && !redirect_valid && (credit_used < DEPTH_C);
    instr_valid = (count != '0);
    push        = inflight && !redirect_valid;
    pop         = instr_valid && instr_ready && !redirect_valid;
    instruction = instr_valid ? word_q[head] : '0;
    instr_pc    = instr_valid ? pc_q[head]   : '0;
  end

  assign imem_addr = fetch_pc[ADDR_W+1:2];

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      word_q[tail] <= imem_rdata;
      pc_q[tail]   <= inflight_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc     <= RESET_PC;
      count        <= '0;
      head         <= '0;
      tail         <= '0;
      inflight     <= 1'b0;
      inflight_pc  <= '0;
      misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      // Clearing the in-flight flag kills the outstanding read's returning data.
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      inflight <= 1'b0;
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
    end else begin
      inflight <= imem_rd;
      if (imem_rd) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// traffic compared against a queue-based transaction model.
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] BASE   = 32'h0226_8193;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = '0;
  logic              imem_rd;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic [31:0]       instruction;
  logic [31:0]       instr_pc;
  logic [31:0]       fetch_pc;
  logic              misalign_err;

  logic              w_rst = 1'b1;
  logic              w_rd;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_rdata;
  logic              w_valid;
  logic [31:0]       w_instruction;
  logic [31:0]       w_pc;
  logic [31:0]       w_fpc;
  logic              w_err;

  logic [31:0] mem [512];

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instruction(instruction),
    .instr_pc(instr_pc), .fetch_pc(fetch_pc), .misalign_err(misalign_err)
  );

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(32'h7F8)) u_wrap (
    .clk(clk), .rst(w_rst), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_rd(w_rd), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .instr_valid(w_valid), .instr_ready(1'b1), .instruction(w_instruction),
    .instr_pc(w_pc), .fetch_pc(w_fpc), .misalign_err(w_err)
  );

  always @(posedge clk) begin
    if (imem_rd) imem_rdata <= mem[imem_addr];
    if (w_rd)    w_rdata    <= mem[w_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction model: buffered PCs in a queue, words looked up from memory by PC.
  logic [31:0] q_pc[$];
  bit          m_infl;
  logic [31:0] m_infl_pc;
  logic [31:0] m_fpc;
  bit          m_err;

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    logic [8:0] idx;
    idx = pc[10:2];
    return mem[idx];
  endfunction

  task automatic step();
    int unsigned used;
    bit          exp_rd;
    bit          has;
    logic [31:0] hpc;
    used   = q_pc.size() + (m_infl ? 1 : 0);
    exp_rd = !rst && !redirect_valid && (used < DEPTH);
    has    = (q_pc.size() != 0);
    hpc    = has ? q_pc[0] : 32'h0;
    check("imem_rd", imem_rd, exp_rd);
    check("fetch_pc", fetch_pc, m_fpc);
    check("imem_addr", 32'(imem_addr), 32'(m_fpc[ADDR_W+1:2]));
    check("instr_valid", instr_valid, has);
    check("instr_pc", instr_pc, hpc);
    check("instruction", instruction, has ? word_at(hpc) : 32'h0);
    check("misalign_err", misalign_err, m_err);
    if (rst) begin
      q_pc.delete();
      m_infl = 0;
      m_fpc  = 32'h0;
      m_err  = 0;
    end else if (redirect_valid) begin
      q_pc.delete();
      m_infl = 0;
      m_fpc  = {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) m_err = 1;
    end else begin
      if (has && instr_ready) void'(q_pc.pop_front());
      if (m_infl) q_pc.push_back(m_infl_pc);
      m_infl = exp_rd;
      if (exp_rd) begin
        m_infl_pc = m_fpc;
        m_fpc     = m_fpc + 32'd4;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit rv, input logic [31:0] rp, input bit rdy);
    @(negedge clk);
    rst            = r;
    w_rst          = r;
    redirect_valid = rv;
    redirect_pc    = rp;
    instr_ready    = rdy;
    #1;
    step();
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  int unsigned w_exp_addr[4] = '{510, 511, 0, 1};

  initial begin
    for (int k = 0; k < 512; k++) mem[k] = BASE + 32'(k);
    repeat (2) @(posedge clk);
    q_pc.delete();
    m_infl = 0; m_infl_pc = '0; m_fpc = 32'h0; m_err = 0;

    // Reset then stream, with the wrap instance running alongside.
    do_reset();
    check("rst_valid", instr_valid, 1'b0);
    check("rst_rd", imem_rd, 1'b0);
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      if (c >= 2) begin
        check("s_valid", instr_valid, 1'b1);
        check("s_pc", instr_pc, 32'(4 * (c - 2)));
        check("s_word", instruction, BASE + 32'(c - 2));
      end else begin
        check("s_empty", instr_valid, 1'b0);
      end
      if (c < 4) check("w_addr", 32'(w_addr), w_exp_addr[c]);
      if (c >= 2 && c < 6) begin
        check("w_pc", w_pc, 32'h7F8 + 32'(4 * (c - 2)));
        check("w_word", w_instruction, BASE + 32'((510 + c - 2) % 512));
      end
    end

    // Backpressure from cycle 0.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      check(c < 4 ? "bp_rd_on" : "bp_rd_off", imem_rd, c < 4);
      if (c >= 5) begin
        check("bp_fpc", fetch_pc, 32'h10);
        check("bp_head", instr_pc, 32'h0);
      end
    end
    for (int c = 0; c < 8; c++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      if (c == 0) check("bp_hold", imem_rd, 1'b0);
      if (c == 1) check("bp_resume", imem_rd, 1'b1);
      check("bp_valid", instr_valid, 1'b1);
      check("bp_pop_pc", instr_pc, 32'(4 * c));
    end

    // Redirect with two buffered entries and one read in flight.
    do_reset();
    for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h40, 1'b1);
    check("rd_pre_valid", instr_valid, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      if (c == 1) begin
        check("rd_fpc", fetch_pc, 32'h40);
        check("rd_issue", imem_rd, 1'b1);
      end
      if (c < 3) check("rd_gap", instr_valid, 1'b0);
      if (c >= 3) begin
        check("rd_pc", instr_pc, 32'h40 + 32'(4 * (c - 3)));
        check("rd_word", instruction, BASE + 32'(16 + c - 3));
      end
    end

    // Misaligned redirect: sticky flag, fetch resumes at the aligned PC.
    cycle(1'b0, 1'b1, 32'h42, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      check("ma_err", misalign_err, 1'b1);
      if (c == 1) check("ma_fpc", fetch_pc, 32'h40);
      if (c == 3) check("ma_pc", instr_pc, 32'h40);
    end
    cycle(1'b0, 1'b1, 32'h100, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("ma_sticky", misalign_err, 1'b1);
    do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("ma_clear", misalign_err, 1'b0);

    // Reset with the FIFO full and the core stalled.
    do_reset();
    for (int c = 0; c < 6; c++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("mr_full", instr_valid, 1'b1);
    do_reset();
    do_reset();
    check("mr_rd", imem_rd, 1'b0);
    check("mr_valid", instr_valid, 1'b0);
    check("mr_instr", instruction, 32'h0);
    check("mr_pc", instr_pc, 32'h0);
    check("mr_fpc", fetch_pc, 32'h0);
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      check("mr_first_valid", instr_valid, c == 2);
      if (c == 2) check("mr_first_pc", instr_pc, 32'h0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0,
            32'($urandom_range(0, 2047)), $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
